// File: rtl/lfsr_source_if.sv
// Control and observation bundle for the lfsr_source random bit generator.
interface lfsr_source_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] lfsr_q;
  logic             lfsr;
  logic             step;
  logic             lockup;

  modport master (
    output en, seed_load, seed_in,
    input  lfsr_q, lfsr, step, lockup
  );

  modport slave (
    input  en, seed_load, seed_in,
    output lfsr_q, lfsr, step, lockup
  );
endinterface

// File: rtl/lfsr_source.sv
// Prescaled Galois LFSR with seed loading and zero-seed lockup protection.
// Optional LFSR_HOLD_EN: lfsr bit only follows two consecutive equal samples.
module lfsr_source #(
  parameter int                   WIDTH    = 16,
  parameter logic [WIDTH-1:0]     TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0]     SEED     = 16'hACE1,
  parameter int                   PRESCALE = 1000
) (
  input  logic         clk,
  input  logic         reset,
  lfsr_source_if.slave bus
);
  localparam int              CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_state;
  logic             bit_q;
  logic             step_q;
  logic             lockup_q;
`ifdef LFSR_HOLD_EN
  logic             hold_prev;
  logic             hold_armed;
`endif

  // A zero result is unreachable with a sane mask, but recover to SEED anyway.
  always_comb begin
    shifted    = state >> 1;
    next_state = state[0] ? (shifted ^ TAPS) : shifted;
    if (next_state == '0) next_state = SEED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      state    <= SEED;
      bit_q    <= SEED[0];
      step_q   <= 1'b0;
      lockup_q <= 1'b0;
`ifdef LFSR_HOLD_EN
      hold_prev  <= 1'b0;
      hold_armed <= 1'b0;
`endif
    end else begin
      step_q   <= 1'b0;
      lockup_q <= 1'b0;
      if (bus.seed_load) begin
        count <= '0;
        if (bus.seed_in == '0) begin
          state    <= SEED;
          bit_q    <= SEED[0];
          lockup_q <= 1'b1;
        end else begin
          state <= bus.seed_in;
          bit_q <= bus.seed_in[0];
        end
`ifdef LFSR_HOLD_EN
        hold_armed <= 1'b0;
`endif
      end else if (bus.en) begin
        if (count == LAST) begin
          count  <= '0;
          state  <= next_state;
          step_q <= 1'b1;
`ifdef LFSR_HOLD_EN
          if (hold_armed && (next_state[0] == hold_prev)) bit_q <= next_state[0];
          hold_prev  <= next_state[0];
          hold_armed <= 1'b1;
`else
          bit_q <= next_state[0];
`endif
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign bus.lfsr_q = state;
  assign bus.lfsr   = bit_q;
  assign bus.step   = step_q;
  assign bus.lockup = lockup_q;
endmodule

// File: tb/tb_lfsr_source.sv
// Directed bench for lfsr_source with PRESCALE=4 and default taps/seed.
module tb_lfsr_source;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  lfsr_source_if #(.WIDTH(16)) bus ();

  lfsr_source #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] exp_q   [0:3];
  logic        exp_bit [0:3];
  logic        hold_b;
  logic        adv;

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_q[0] = 16'hACE1; exp_q[1] = 16'hE270; exp_q[2] = 16'h7138; exp_q[3] = 16'h389C;
`ifdef LFSR_HOLD_EN
    exp_bit[0] = 1'b1; exp_bit[1] = 1'b1; exp_bit[2] = 1'b0; exp_bit[3] = 1'b0;
    hold_b = 1'b1;
`else
    exp_bit[0] = 1'b1; exp_bit[1] = 1'b0; exp_bit[2] = 1'b0; exp_bit[3] = 1'b0;
    hold_b = 1'b0;
`endif
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_q",      32'(bus.lfsr_q), 32'h0000ACE1);
    check("rst_lfsr",   32'(bus.lfsr),   32'd1);
    check("rst_step",   32'(bus.step),   32'd0);
    check("rst_lockup", 32'(bus.lockup), 32'd0);
    reset = 1'b0;

    // free run: advances on every 4th enabled edge
    bus.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      adv = ((k % 4) == 0);
      check($sformatf("run_step%0d", k), 32'(bus.step),   32'(adv));
      check($sformatf("run_q%0d", k),    32'(bus.lfsr_q), 32'(exp_q[k/4]));
      check($sformatf("run_bit%0d", k),  32'(bus.lfsr),   32'(exp_bit[k/4]));
    end

    // gated enable 1,1,0,0,0,1,1: advance only on the 7th edge
    for (int k = 1; k <= 7; k++) begin
      bus.en = (k <= 2 || k >= 6);
      cyc();
      check($sformatf("gate_step%0d", k), 32'(bus.step), 32'(k == 7));
      check($sformatf("gate_q%0d", k), 32'(bus.lfsr_q), (k == 7) ? 32'h00001C4E : 32'h0000389C);
    end
    check("gate_bit", 32'(bus.lfsr), 32'd0);

    // load of 0001 colliding with a due advance
    bus.en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("pre_step%0d", k), 32'(bus.step), 32'd0);
    end
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0001;
    cyc();
    bus.seed_load = 1'b0;
    check("ld1_q",      32'(bus.lfsr_q), 32'h00000001);
    check("ld1_step",   32'(bus.step),   32'd0);
    check("ld1_lockup", 32'(bus.lockup), 32'd0);
    check("ld1_bit",    32'(bus.lfsr),   32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("ld1_after_step%0d", k), 32'(bus.step), 32'(k == 4));
    end
    check("ld1_adv_q",   32'(bus.lfsr_q), 32'h0000B400);
    check("ld1_adv_bit", 32'(bus.lfsr),   32'(hold_b));

    // zero seed rejected, en low
    bus.en        = 1'b0;
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0000;
    cyc();
    bus.seed_load = 1'b0;
    check("ld0_q",      32'(bus.lfsr_q), 32'h0000ACE1);
    check("ld0_lockup", 32'(bus.lockup), 32'd1);
    check("ld0_bit",    32'(bus.lfsr),   32'd1);
    cyc();
    check("ld0_lockup_end", 32'(bus.lockup), 32'd0);

    // nonzero load with en low, then reset mid-count
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h1234;
    cyc();
    bus.seed_load = 1'b0;
    check("ld_en0_q",      32'(bus.lfsr_q), 32'h00001234);
    check("ld_en0_lockup", 32'(bus.lockup), 32'd0);
    bus.en = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("mid_rst_q",   32'(bus.lfsr_q), 32'h0000ACE1);
    check("mid_rst_bit", 32'(bus.lfsr),   32'd1);
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("post_rst_step%0d", k), 32'(bus.step), 32'(k == 4));
    end
    check("post_rst_q",   32'(bus.lfsr_q), 32'h0000E270);
    check("post_rst_bit", 32'(bus.lfsr),   32'(hold_b));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
